// File: rtl/arith_pkg.sv
// Shared arithmetic constants for the datapath leaf blocks.
package arith_pkg;

    localparam int DEFAULT_ADD_WIDTH = 1;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell; chained by full_adder to form a ripple-carry adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder with combinational sum/carry/overflow
// and a one-cycle registered copy of the same result.
import arith_pkg::*;

module full_adder #(
    parameter int WIDTH = DEFAULT_ADD_WIDTH
) (
    output logic [WIDTH-1:0] s,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst,
    output logic             ovf,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             ovf_q
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[WIDTH];
    assign ovf  = c[WIDTH-1] ^ c[WIDTH];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;

    int total = 0;
    int bad   = 0;

    // WIDTH=1 instance, clock and reset tied low
    logic       a1, b1, cin1;
    logic       s1, cout1, ovf1, s_q1, cout_q1, ovf_q1;

    // WIDTH=4 instance with free-running clock
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a4, b4, s4, s_q4;
    logic       cin4, cout4, ovf4, cout_q4, ovf_q4;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_fa1 (
        .s      (s1),
        .cout   (cout1),
        .a      (a1),
        .b      (b1),
        .cin    (cin1),
        .clk    (1'b0),
        .rst    (1'b0),
        .ovf    (ovf1),
        .s_q    (s_q1),
        .cout_q (cout_q1),
        .ovf_q  (ovf_q1)
    );

    full_adder #(.WIDTH(4)) u_fa4 (
        .s      (s4),
        .cout   (cout4),
        .a      (a4),
        .b      (b4),
        .cin    (cin4),
        .clk    (clk),
        .rst    (rst),
        .ovf    (ovf4),
        .s_q    (s_q4),
        .cout_q (cout_q4),
        .ovf_q  (ovf_q4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic comb4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [3:0] es, input logic ec, input logic eo);
        a4 = a; b4 = b; cin4 = ci;
        #1;
        check($sformatf("s4 %h+%h+%b", a, b, ci), 32'(s4), 32'(es));
        check($sformatf("cout4 %h+%h+%b", a, b, ci), 32'(cout4), 32'(ec));
        check($sformatf("ovf4 %h+%h+%b", a, b, ci), 32'(ovf4), 32'(eo));
    endtask

    // Hand-computed {cout,s} for {a,b,cin} = 000..111
    logic [1:0] exp1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        a4   = '0; b4 = '0; cin4 = 1'b0;
        a1   = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #1;
        check("reset s_q", 32'(s_q4), 32'h0);
        check("reset cout_q", 32'(cout_q4), 32'h0);
        check("reset ovf_q", 32'(ovf_q4), 32'h0);

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a1, b1, cin1} = v;
            #1;
            check($sformatf("fa1 {cout,s} in=%b", v), 32'({cout1, s1}), 32'(exp1[i]));
            check($sformatf("fa1 ovf in=%b", v), 32'(ovf1), 32'(v[0] ^ exp1[i][1]));
            #9;
        end

        // WIDTH=4 combinational and boundary vectors
        comb4(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);
        comb4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        comb4(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
        comb4(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        comb4(4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0);
        comb4(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
        check("s_q held in reset", 32'(s_q4), 32'h0);

        // Registered latency
        @(negedge clk);
        rst = 1'b0;
        a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1;
        @(posedge clk);
        #1;
        check("s_q after edge", 32'(s_q4), 32'h8);
        check("cout_q after edge", 32'(cout_q4), 32'h0);
        check("ovf_q after edge", 32'(ovf_q4), 32'h1);
        a4 = 4'h1; b4 = 4'h1; cin4 = 1'b0;
        #2;
        check("s comb mid-cycle", 32'(s4), 32'h2);
        check("s_q held between edges", 32'(s_q4), 32'h8);
        a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1;
        #1;

        // Async reset between edges
        rst = 1'b1;
        #1;
        check("async rst s_q", 32'(s_q4), 32'h0);
        check("async rst cout_q", 32'(cout_q4), 32'h0);
        check("async rst ovf_q", 32'(ovf_q4), 32'h0);
        check("s unaffected by rst", 32'(s4), 32'h8);
        @(posedge clk);
        #1;
        check("s_q held across edge in rst", 32'(s_q4), 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("s_q no capture before edge", 32'(s_q4), 32'h0);
        @(posedge clk);
        #1;
        check("s_q capture after release", 32'(s_q4), 32'h8);
        check("ovf_q capture after release", 32'(ovf_q4), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
